// File: rtl/seq_shifter_pkg.sv
// Shared encodings for the multi-cycle shift unit: shift modes and FSM states.
package seq_shifter_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/seq_shift_step.sv
// Combinational single-bit shift step; out_bit_c is the bit leaving the word.
module seq_shift_step
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_value_c,
  output logic             out_bit_c
);

  always_comb begin
    next_value_c = value;
    out_bit_c    = 1'b0;
    case (mode)
      MODE_LSL: begin
        next_value_c = {value[WIDTH-2:0], 1'b0};
        out_bit_c    = value[WIDTH-1];
      end
      MODE_LSR: begin
        next_value_c = {1'b0, value[WIDTH-1:1]};
        out_bit_c    = value[0];
      end
      MODE_ASR: begin
        next_value_c = {value[WIDTH-1], value[WIDTH-1:1]};
        out_bit_c    = value[0];
      end
      default: begin
        next_value_c = {value[WIDTH-2:0], value[WIDTH-1]};
        out_bit_c    = value[WIDTH-1];
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock, start/done handshake,
// LSL overflow accumulated from every bit pushed out of the MSB.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  logic [1:0]         state, state_nxt;
  logic [WIDTH-1:0]   work, work_nxt;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic               acc, acc_nxt;
  logic [WIDTH-1:0]   step_val_c;
  logic               step_out_c;

  seq_shift_step #(.WIDTH(WIDTH)) u_step (
    .value        (work),
    .mode         (mode_q),
    .next_value_c (step_val_c),
    .out_bit_c    (step_out_c)
  );

  // Next-state, datapath and counter update.
  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    acc_nxt   = acc;
    case (state)
      ST_IDLE: begin
        if (start) begin
          work_nxt  = a;
          cnt_nxt   = shamt;
          mode_nxt  = mode;
          acc_nxt   = 1'b0;
          state_nxt = (shamt == SHAMT_W'(0)) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_nxt = step_val_c;
        cnt_nxt  = cnt - SHAMT_W'(1);
        if (mode_q == MODE_LSL) acc_nxt = acc | step_out_c;
        if (cnt == SHAMT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      work     <= '0;
      cnt      <= '0;
      mode_q   <= MODE_LSL;
      acc      <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      work   <= work_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
      acc    <= acc_nxt;
      ready  <= (state_nxt == ST_IDLE);
      busy   <= (state_nxt != ST_IDLE);
      done   <= (state_nxt == ST_DONE);
      if (state_nxt == ST_DONE) begin
        result   <= work_nxt;
        overflow <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=16) with a transaction-level reference
// model compared against the outputs every cycle.
module tb_seq_shifter;

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [SW-1:0] shamt = '0;
  logic [1:0]    mode = 2'b00;
  logic          ready, busy, done, overflow;
  logic [W-1:0]  result;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  seq_shifter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .shamt    (shamt),
    .mode     (mode),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Expected {overflow, result} straight from the mode definitions.
  function automatic logic [W:0] model_op(input logic [W-1:0] x, input logic [SW-1:0] s,
                                          input logic [1:0] m);
    logic [2*W-1:0] w;
    logic [W-1:0]   r;
    case (m)
      2'b00: begin
        w = {16'h0000, x} << s;
        return {|w[2*W-1:W], w[W-1:0]};
      end
      2'b01: begin
        r = x >> s;
        return {1'b0, r};
      end
      2'b10: begin
        r = $signed(x) >>> s;
        return {1'b0, r};
      end
      default: begin
        w = {x, x} << s;
        return {1'b0, w[2*W-1:W]};
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: done appears shamt+1 cycles after the start cycle.
  bit           m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_res = '0;
  int           m_rem = 0;
  logic [W-1:0] m_a;
  logic [SW-1:0] m_s;
  logic [1:0]   m_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_ovf = 1'b0; m_rem = 0;
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        {m_ovf, m_res} = model_op(m_a, m_s, m_m);
      end
    end else if (start) begin
      m_busy = 1'b1; m_a = a; m_s = shamt; m_m = mode; m_rem = int'(shamt);
      if (shamt == 4'd0) begin
        m_done = 1'b1;
        {m_ovf, m_res} = model_op(a, shamt, mode);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst)
      chk("cycle {ready,busy,done,ovf,result}",
          32'({ready, busy, done, overflow, result}),
          32'({~m_busy, m_busy, m_done, m_ovf, m_res}));
  end

  // Start one operation, scramble inputs after acceptance, check result and latency.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [SW-1:0] ts,
                        input logic [1:0] tm, input logic [W-1:0] er, input logic eo,
                        input int el);
    int k;
    @(negedge clk);
    a = ta; shamt = ts; mode = tm; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; shamt = ~ts; mode = tm ^ 2'b01;
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, " latency"}, 32'(k), 32'(el));
    chk({name, " result"}, 32'(result), 32'(er));
    chk({name, " overflow"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    run_op("lsl1", 16'h1082, 4'd1, 2'b00, 16'h2104, 1'b0, 2);
    run_op("lsl_ovf1", 16'h8003, 4'd1, 2'b00, 16'h0006, 1'b1, 2);
    run_op("lsl_ovf2", 16'h4000, 4'd2, 2'b00, 16'h0000, 1'b1, 3);
    run_op("asr4", 16'hA4F1, 4'd4, 2'b10, 16'hFA4F, 1'b0, 5);
    run_op("lsr4", 16'hA4F1, 4'd4, 2'b01, 16'h0A4F, 1'b0, 5);
    run_op("rol15", 16'h8001, 4'd15, 2'b11, 16'hC000, 1'b0, 16);
    run_op("lsl_late_ovf", 16'h0180, 4'd9, 2'b00, 16'h0000, 1'b1, 10);

    // Zero shift, then a start pulsed during the DONE cycle must be ignored.
    @(negedge clk);
    a = 16'h3488; shamt = 4'd0; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero done at 1", 32'(done), 32'd1);
    chk("zero result", 32'(result), 32'h3488);
    chk("zero overflow", 32'(overflow), 32'd0);
    ndone = done ? 1 : 0;
    a = 16'hFFFF; shamt = 4'd5; mode = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("single done", 32'(ndone), 32'd1);
    chk("ignored start keeps result", 32'(result), 32'h3488);

    // Reset three cycles into a long ASR aborts it without a done pulse.
    @(negedge clk);
    a = 16'h8421; shamt = 4'd10; mode = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort ready", 32'(ready), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no done after abort", 32'(ndone), 32'd0);
    run_op("post_reset_lsl", 16'h0011, 4'd3, 2'b00, 16'h0088, 1'b0, 4);

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
